// File: rtl/scalar_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// scalar_scoreboard_pkg
// Shared types for the scalar scoreboard: FU enumeration, per-row FSM states,
// the FUST row layout and the full table snapshot type.
// No ports (package).
// -----------------------------------------------------------------------------
package scalar_scoreboard_pkg;

    localparam int NUM_FU_S = 3;
    localparam int REG_W_S  = 5;
    localparam int TAG_W_S  = 2;

    localparam logic [TAG_W_S-1:0] TAG_READY = '0;

    typedef enum logic [1:0] {
        FU_ALU    = 2'd0,
        FU_LD_ST  = 2'd1,
        FU_BRANCH = 2'd2
    } fu_scalar_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OPS = 2'd1,
        READY    = 2'd2,
        EXEC     = 2'd3
    } row_state_t;

    typedef struct packed {
        row_state_t           state;
        logic                 busy;
        logic [REG_W_S-1:0]   r;
        logic [REG_W_S-1:0]   r1;
        logic [REG_W_S-1:0]   r2;
        logic [TAG_W_S-1:0]   t1;
        logic [TAG_W_S-1:0]   t2;
    } fust_row_t;

    typedef fust_row_t [NUM_FU_S-1:0] fust_s_t;

    // Producer tag for FU f: 0 is reserved for "operand ready".
    function automatic logic [TAG_W_S-1:0] fu_tag(input int f);
        return TAG_W_S'(f + 1);
    endfunction

    // Clears a tag whose producer completes this cycle.
    function automatic logic [TAG_W_S-1:0] wake_tag(
        input logic [TAG_W_S-1:0]  tag,
        input logic [NUM_FU_S-1:0] done
    );
        logic [TAG_W_S-1:0] res;
        res = tag;
        for (int f = 0; f < NUM_FU_S; f++) begin
            if (done[f] && tag == fu_tag(f)) res = TAG_READY;
        end
        return res;
    endfunction

endpackage

// File: rtl/scalar_scoreboard_rstat_table.sv
// -----------------------------------------------------------------------------
// scalar_scoreboard_rstat_table
// Register result-status table: one producer tag per architectural register.
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   rd0/rd1/rd2_idx -> _tag   three combinational read ports
//   set_en/idx/tag            single write port (dispatch of a new producer)
//   clr_en/idx/tag            one clear port per FU (completion)
// A clear only takes effect while the entry still holds that FU's tag, and a
// set to the same entry in the same cycle wins over any clear.
// -----------------------------------------------------------------------------
module scalar_scoreboard_rstat_table #(
    parameter int REG_W  = 5,
    parameter int TAG_W  = 2,
    parameter int NUM_FU = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [REG_W-1:0]        rd0_idx,
    input  logic [REG_W-1:0]        rd1_idx,
    input  logic [REG_W-1:0]        rd2_idx,
    output logic [TAG_W-1:0]        rd0_tag,
    output logic [TAG_W-1:0]        rd1_tag,
    output logic [TAG_W-1:0]        rd2_tag,
    input  logic                    set_en,
    input  logic [REG_W-1:0]        set_idx,
    input  logic [TAG_W-1:0]        set_tag,
    input  logic [NUM_FU-1:0]       clr_en,
    input  logic [NUM_FU*REG_W-1:0] clr_idx,
    input  logic [NUM_FU*TAG_W-1:0] clr_tag
);

    logic [TAG_W-1:0] r_tags [2**REG_W];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 2**REG_W; i++) r_tags[i] <= '0;
        end else begin
            for (int i = 0; i < 2**REG_W; i++) begin
                if (set_en && set_idx == REG_W'(i)) begin
                    r_tags[i] <= set_tag;
                end else begin
                    for (int f = 0; f < NUM_FU; f++) begin
                        if (clr_en[f] && clr_idx[f*REG_W +: REG_W] == REG_W'(i) &&
                            r_tags[i] == clr_tag[f*TAG_W +: TAG_W]) begin
                            r_tags[i] <= '0;
                        end
                    end
                end
            end
        end
    end

    assign rd0_tag = r_tags[rd0_idx];
    assign rd1_tag = r_tags[rd1_idx];
    assign rd2_tag = r_tags[rd2_idx];

endmodule

// File: rtl/scalar_scoreboard.sv
// -----------------------------------------------------------------------------
// scalar_scoreboard
// Scalar FU status table plus register result-status table between dispatch
// and the ALU / LD_ST / BRANCH units.
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   disp_valid/fu/rd/rs1/rs2      dispatched instruction
//   disp_hazard, disp_accept      structural/WAW stall and accept (comb)
//   issue_valid, issue_ready      per-FU issue handshake
//   issue_regs                    per FU {rd,rs1,rs2}, FU f at [f*3*REG_W +: 3*REG_W]
//   wb_req, wb_ok                 per-FU writeback handshake (wb_ok gates WAR)
//   fust_out                      table snapshot
// Optional macro SCOREBOARD_WB_RELEASE_EN: a row completing this cycle may be
// re-dispatched in the same cycle (no bubble).
//
// Row FSM:
//   state    | meaning
//   IDLE     | row free
//   WAIT_OPS | accepted, at least one source tag pending
//   READY    | operands ready, issue_valid asserted
//   EXEC     | FU has read operands, waiting for writeback
// -----------------------------------------------------------------------------
module scalar_scoreboard
    import scalar_scoreboard_pkg::*;
#(
    parameter int NUM_FU = NUM_FU_S,
    parameter int REG_W  = REG_W_S,
    parameter int TAG_W  = TAG_W_S
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      disp_valid,
    input  logic [1:0]                disp_fu,
    input  logic [REG_W-1:0]          disp_rd,
    input  logic [REG_W-1:0]          disp_rs1,
    input  logic [REG_W-1:0]          disp_rs2,
    output logic                      disp_hazard,
    output logic                      disp_accept,
    output logic [NUM_FU-1:0]         issue_valid,
    input  logic [NUM_FU-1:0]         issue_ready,
    output logic [NUM_FU*3*REG_W-1:0] issue_regs,
    input  logic [NUM_FU-1:0]         wb_req,
    output logic [NUM_FU-1:0]         wb_ok,
    output fust_s_t                   fust_out
);

    fust_s_t                  r_fust;
    logic [NUM_FU-1:0]        w_complete;
    logic [TAG_W-1:0]         w_rs1_tag, w_rs2_tag, w_rd_tag;
    logic [TAG_W-1:0]         w_t1_new, w_t2_new;
    logic [TAG_W-1:0]         w_t1_woken [NUM_FU];
    logic [TAG_W-1:0]         w_t2_woken [NUM_FU];
    logic                     w_fu_ok, w_struct, w_waw, w_accept;
    logic [NUM_FU*REG_W-1:0]  w_clr_idx;
    logic [NUM_FU*TAG_W-1:0]  w_clr_tag;
    logic [NUM_FU-1:0]        w_clr_en;

    // WAR check: another waiting/ready row still needs the old value of r_f
    // if it reads r_f but its tag does not point at FU f.
    always_comb begin
        wb_ok = '1;
        for (int f = 0; f < NUM_FU; f++) begin
            for (int g = 0; g < NUM_FU; g++) begin
                if (g != f && r_fust[f].r != '0 &&
                    (r_fust[g].state == WAIT_OPS || r_fust[g].state == READY) &&
                    ((r_fust[g].r1 == r_fust[f].r && r_fust[g].t1 != fu_tag(f)) ||
                     (r_fust[g].r2 == r_fust[f].r && r_fust[g].t2 != fu_tag(f)))) begin
                    wb_ok[f] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int f = 0; f < NUM_FU; f++) begin
            w_complete[f]  = wb_req[f] && wb_ok[f] && (r_fust[f].state == EXEC);
            issue_valid[f] = (r_fust[f].state == READY);
            issue_regs[f*3*REG_W +: 3*REG_W] = {r_fust[f].r, r_fust[f].r1, r_fust[f].r2};
            w_clr_en[f]    = w_complete[f] && (r_fust[f].r != '0);
            w_clr_idx[f*REG_W +: REG_W] = r_fust[f].r;
            w_clr_tag[f*TAG_W +: TAG_W] = fu_tag(f);
        end
        for (int f = 0; f < NUM_FU; f++) begin
            w_t1_woken[f] = wake_tag(r_fust[f].t1, w_complete);
            w_t2_woken[f] = wake_tag(r_fust[f].t2, w_complete);
        end
    end

    // An encoding beyond the last FU is treated as permanently busy.
    assign w_fu_ok = int'(disp_fu) < NUM_FU;

`ifdef SCOREBOARD_WB_RELEASE_EN
    assign w_struct = !w_fu_ok || (r_fust[disp_fu].busy && !w_complete[disp_fu]);
`else
    assign w_struct = !w_fu_ok || r_fust[disp_fu].busy;
`endif

    assign w_waw       = (disp_rd != '0) && (w_rd_tag != TAG_READY);
    assign disp_hazard = disp_valid && (w_struct || w_waw);
    assign w_accept    = disp_valid && !disp_hazard;
    assign disp_accept = w_accept;

    // Captured tags also see same-cycle completions so no wakeup is lost.
    assign w_t1_new = (disp_rs1 == '0) ? TAG_READY : wake_tag(w_rs1_tag, w_complete);
    assign w_t2_new = (disp_rs2 == '0) ? TAG_READY : wake_tag(w_rs2_tag, w_complete);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fust <= '0;
        end else begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (w_accept && int'(disp_fu) == f) begin
                    r_fust[f].busy  <= 1'b1;
                    r_fust[f].state <= (w_t1_new != TAG_READY || w_t2_new != TAG_READY)
                                       ? WAIT_OPS : READY;
                    r_fust[f].r     <= disp_rd;
                    r_fust[f].r1    <= disp_rs1;
                    r_fust[f].r2    <= disp_rs2;
                    r_fust[f].t1    <= w_t1_new;
                    r_fust[f].t2    <= w_t2_new;
                end else if (w_complete[f]) begin
                    r_fust[f] <= '0;
                end else begin
                    r_fust[f].t1 <= w_t1_woken[f];
                    r_fust[f].t2 <= w_t2_woken[f];
                    case (r_fust[f].state)
                        WAIT_OPS: if (w_t1_woken[f] == TAG_READY && w_t2_woken[f] == TAG_READY)
                                      r_fust[f].state <= READY;
                        READY:    if (issue_ready[f]) r_fust[f].state <= EXEC;
                        default:  ;
                    endcase
                end
            end
        end
    end

    scalar_scoreboard_rstat_table #(
        .REG_W  (REG_W),
        .TAG_W  (TAG_W),
        .NUM_FU (NUM_FU)
    ) u_rstat (
        .CLK     (CLK),
        .RST     (RST),
        .rd0_idx (disp_rs1),
        .rd1_idx (disp_rs2),
        .rd2_idx (disp_rd),
        .rd0_tag (w_rs1_tag),
        .rd1_tag (w_rs2_tag),
        .rd2_tag (w_rd_tag),
        .set_en  (w_accept && disp_rd != '0),
        .set_idx (disp_rd),
        .set_tag (TAG_W'(int'(disp_fu) + 1)),
        .clr_en  (w_clr_en),
        .clr_idx (w_clr_idx),
        .clr_tag (w_clr_tag)
    );

    assign fust_out = r_fust;

endmodule

// File: tb/tb_scalar_scoreboard.sv
// Directed bench for scalar_scoreboard. Inputs change 1 ns after the rising
// edge; outputs are sampled 1 ns later, well away from the next edge.
module tb_scalar_scoreboard;
    import scalar_scoreboard_pkg::*;

    localparam int ALU = 0, LDS = 1, BR = 2;
`ifdef SCOREBOARD_WB_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        disp_valid;
    logic [1:0]  disp_fu;
    logic [4:0]  disp_rd, disp_rs1, disp_rs2;
    logic        disp_hazard, disp_accept;
    logic [2:0]  issue_valid, issue_ready, wb_req, wb_ok;
    logic [44:0] issue_regs;
    fust_s_t     fust_out;

    int n_checks = 0;
    int n_fail   = 0;

    scalar_scoreboard dut (
        .CLK         (CLK),
        .RST         (RST),
        .disp_valid  (disp_valid),
        .disp_fu     (disp_fu),
        .disp_rd     (disp_rd),
        .disp_rs1    (disp_rs1),
        .disp_rs2    (disp_rs2),
        .disp_hazard (disp_hazard),
        .disp_accept (disp_accept),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_regs  (issue_regs),
        .wb_req      (wb_req),
        .wb_ok       (wb_ok),
        .fust_out    (fust_out)
    );

    always #5 CLK = ~CLK;

    // Writeback must only be requested by an FU whose row is executing.
    always @(posedge CLK) begin
        if (!RST) begin
            for (int f = 0; f < 3; f++) begin
                if (wb_req[f]) assert (fust_out[f].state == EXEC)
                    else $error("wb_req[%0d] while row not in EXEC", f);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic disp(input int fu, input int rd, input int rs1, input int rs2);
        disp_valid = 1'b1;
        disp_fu    = 2'(fu);
        disp_rd    = 5'(rd);
        disp_rs1   = 5'(rs1);
        disp_rs2   = 5'(rs2);
        #1;
    endtask

    task automatic idle_in();
        disp_valid = 1'b0;
        disp_fu    = '0;
        disp_rd    = '0;
        disp_rs1   = '0;
        disp_rs2   = '0;
        #1;
    endtask

    initial begin
        RST = 1'b1;
        issue_ready = '0;
        wb_req = '0;
        idle_in();
        repeat (2) tick();
        chk("rst_issue_valid", 128'(issue_valid), 128'(3'b000));
        chk("rst_wb_ok",       128'(wb_ok),       128'(3'b111));
        chk("rst_hazard",      128'(disp_hazard), 128'(1'b0));
        chk("rst_fust",        128'(fust_out),    128'(0));
        RST = 1'b0;

        // Basic accept and next-cycle issue
        disp(ALU, 3, 1, 2);
        chk("alu_accept", 128'(disp_accept), 128'(1'b1));
        tick(); idle_in();
        chk("alu_issue_valid", 128'(issue_valid), 128'(3'b001));
        chk("alu_state_ready", 128'(fust_out[ALU].state), 128'(READY));
        chk("alu_issue_regs", 128'(issue_regs[14:0]), 128'({5'd3, 5'd1, 5'd2}));
        disp(LDS, 3, 0, 0);
        chk("waw_r3_hazard", 128'(disp_hazard), 128'(1'b1));
        chk("waw_r3_accept", 128'(disp_accept), 128'(1'b0));

        // RAW: branch waits on ALU, woken by completion
        disp(BR, 0, 3, 0);
        chk("br_accept", 128'(disp_accept), 128'(1'b1));
        tick(); idle_in();
        chk("br_t1_pending", 128'(fust_out[BR].t1), 128'(2'd1));
        chk("br_wait_ops", 128'(fust_out[BR].state), 128'(WAIT_OPS));
        chk("br_not_issued", 128'(issue_valid), 128'(3'b001));
        issue_ready = 3'b001; tick(); issue_ready = '0; #1;
        chk("alu_exec", 128'(fust_out[ALU].state), 128'(EXEC));
        chk("alu_no_reissue", 128'(issue_valid), 128'(3'b000));
        chk("raw_wb_ok", 128'(wb_ok), 128'(3'b111));
        wb_req = 3'b001; tick(); wb_req = '0; #1;
        chk("br_t1_woken", 128'(fust_out[BR].t1), 128'(2'd0));
        chk("br_ready", 128'(fust_out[BR].state), 128'(READY));
        chk("br_issue_valid", 128'(issue_valid), 128'(3'b100));
        chk("alu_idle", 128'(fust_out[ALU]), 128'(0));
        disp(LDS, 3, 0, 0);
        chk("r3_cleared", 128'(disp_hazard), 128'(1'b0));
        idle_in();
        issue_ready = 3'b100; tick(); issue_ready = '0;
        wb_req = 3'b100; tick(); wb_req = '0; #1;
        chk("all_idle_1", 128'(fust_out), 128'(0));

        // WAW and structural hazards
        disp(ALU, 5, 0, 0); tick(); idle_in();
        disp(LDS, 5, 0, 0);
        chk("waw_r5", 128'(disp_hazard), 128'(1'b1));
        disp(ALU, 6, 0, 0);
        chk("struct_alu", 128'(disp_hazard), 128'(1'b1));
        idle_in();
        issue_ready = 3'b001; tick(); issue_ready = '0;
        wb_req = 3'b001; tick(); wb_req = '0; #1;

        // WAR: branch reads r4 (ready), ALU writes r4
        disp(BR, 0, 4, 0); tick();
        disp(ALU, 4, 0, 0);
        chk("alu_r4_accept", 128'(disp_accept), 128'(1'b1));
        tick(); idle_in();
        issue_ready = 3'b001; tick(); issue_ready = '0; #1;
        chk("war_wb_ok", 128'(wb_ok), 128'(3'b110));
        chk("war_br_valid", 128'(issue_valid), 128'(3'b100));
        wb_req = 3'b001; tick(); wb_req = '0; #1;
        chk("war_hold_exec", 128'(fust_out[ALU].state), 128'(EXEC));
        issue_ready = 3'b100; tick(); issue_ready = '0; #1;
        chk("war_released", 128'(wb_ok), 128'(3'b111));
        wb_req = 3'b101; tick(); wb_req = '0; #1;
        chk("dual_complete", 128'(fust_out), 128'(0));
        disp(LDS, 4, 0, 0);
        chk("r4_cleared", 128'(disp_hazard), 128'(1'b0));
        idle_in();

        // Same-cycle completion and dependent dispatch
        disp(ALU, 7, 0, 0); tick(); idle_in();
        issue_ready = 3'b001; tick(); issue_ready = '0;
        wb_req = 3'b001;
        disp(LDS, 8, 7, 0);
        chk("bypass_accept", 128'(disp_accept), 128'(1'b1));
        tick(); wb_req = '0; idle_in();
        chk("bypass_t1", 128'(fust_out[LDS].t1), 128'(2'd0));
        chk("bypass_ready", 128'(fust_out[LDS].state), 128'(READY));
        chk("bypass_issue", 128'(issue_valid), 128'(3'b010));
        chk("bypass_alu_free", 128'(fust_out[ALU].busy), 128'(1'b0));

        // Same-FU back-to-back reuse
        disp(ALU, 9, 0, 0); tick(); idle_in();
        issue_ready = 3'b001; tick(); issue_ready = '0;
        wb_req = 3'b001;
        disp(ALU, 10, 0, 0);
        chk("reuse_hazard", 128'(disp_hazard), 128'(!REL));
        tick(); wb_req = '0; idle_in();
        chk("reuse_state", 128'(fust_out[ALU].state), REL ? 128'(READY) : 128'(IDLE));
        chk("reuse_rd", 128'(fust_out[ALU].r), REL ? 128'(5'd10) : 128'(5'd0));
        disp(BR, 9, 0, 0);
        chk("r9_cleared", 128'(disp_hazard), 128'(1'b0));
        tick(); idle_in();
        if (!REL) begin
            disp(ALU, 12, 0, 0); tick(); idle_in();
        end
        chk("all_busy", 128'({fust_out[BR].busy, fust_out[LDS].busy, fust_out[ALU].busy}),
            128'(3'b111));

        // Reset mid-operation
        RST = 1'b1; tick(); RST = 1'b0; #1;
        chk("mid_rst_fust", 128'(fust_out), 128'(0));
        chk("mid_rst_issue", 128'(issue_valid), 128'(3'b000));
        chk("mid_rst_wb_ok", 128'(wb_ok), 128'(3'b111));
        disp(LDS, 8, 0, 0);
        chk("mid_rst_accept", 128'(disp_accept), 128'(1'b1));
        tick(); idle_in();
        chk("post_rst_ready", 128'(fust_out[LDS].state), 128'(READY));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scalar_scoreboard.md
Name: scalar_scoreboard

Overview:
- Scalar functional-unit status table (FUST) plus register result-status table. Sits between dispatch and the scalar FUs (ALU, LD_ST, BRANCH).
- Accepts one dispatched scalar instruction per cycle and flags structural and WAW hazards back to dispatch.
- Tracks operand producers per FU and raises per-FU issue when operands are ready.
- Gates writeback on WAR hazards and broadcasts completion to wake dependent entries.

Parameters:
- NUM_FU, 3, number of scalar FUs; index = fu_scalar enum value.
- REG_W, 5, register index width.
- TAG_W, 2, producer tag width; 0 = operand ready, k = pending on FU k-1.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- disp_valid  in  1  dispatch has an instruction
- disp_fu  in  2  target FU (fu_scalar)
- disp_rd  in  REG_W  destination; 0 = no destination
- disp_rs1  in  REG_W  source 1; 0 = unused/zero register
- disp_rs2  in  REG_W  source 2; 0 = unused/zero register
- disp_hazard  out  1  structural or WAW stall (combinational)
- disp_accept  out  1  disp_valid && !disp_hazard
- issue_valid  out  NUM_FU  FU row has all operands ready
- issue_ready  in  NUM_FU  FU reads operands this cycle
- issue_regs  out  NUM_FU*3*REG_W  per FU {rd,rs1,rs2}
- wb_req  in  NUM_FU  FU wants to write back
- wb_ok  out  NUM_FU  writeback permitted (no WAR); FU completes on wb_req && wb_ok
- fust_out  out  fust_s_t  table snapshot for debug/visibility

Behaviour:
- Row state per FU: IDLE -> WAIT_OPS (any tag nonzero) or READY (tags zero) on accept; WAIT_OPS -> READY when both tags clear; READY -> EXEC on issue_valid && issue_ready; EXEC -> IDLE on wb_req && wb_ok.
- Accept: the row is written and busy=1 at the next edge. Captured fields:
  - r=rd, r1=rs1, r2=rs2.
  - t1=RSTAT[rs1], t2=RSTAT[rs2]; forced to 0 when the register index is 0.
  - RSTAT[rd]=disp_fu+1 if rd≠0.
- Earliest issue_valid: the cycle after accept.
- disp_hazard = disp_valid && (busy[disp_fu] || (disp_rd≠0 && RSTAT[disp_rd]≠0)).
- wb_ok[f]: 0 if any other row g in WAIT_OPS/READY has (r1_g==r_f && t1_g≠f+1) or (r2_g==r_f && t2_g≠f+1), with r_f≠0; otherwise 1. A row with r_f=0 is always 1.
- Completion of FU f at an edge:
  - Row f -> IDLE and busy=0.
  - Every row tag equal to f+1 -> 0.
  - RSTAT[r_f] -> 0 if it still equals f+1.
  - Dependents see issue_valid the following cycle.
- Simultaneous accept + completion:
  - A new row whose captured tag equals a completing FU gets tag 0. No lost wakeup.
  - RSTAT write from the accept wins over the clear from the completion.
- Multiple FUs may complete in the same cycle; all clears apply.
- issue_valid and wb_ok are combinational from registered state.
- issue_valid=1 only in READY; only one issue per dispatch.
- Reset (any cycle, including mid-operation):
  - All rows IDLE with all fields 0; RSTAT all 0.
  - issue_valid=0, wb_ok=all 1, disp_hazard=0 unless disp_valid, fust_out=0.
  - In-flight FU work is discarded.
- wb_req without the row being in EXEC is ignored. A bench assertion flags it.

Optional Feature:
- Macro: SCOREBOARD_WB_RELEASE_EN.
- Defined: the structural term in disp_hazard ignores busy[disp_fu] when FU disp_fu completes in the same cycle. This gives back-to-back reuse; the new row overwrites at the edge.
- Undefined: busy alone blocks, with 1-cycle bubble after completion.

Decomposition:
- types_pkg gains:
  - NUM_FU_S=3.
  - fust_s_t resized to NUM_FU_S rows; fix the current FU_S_W-row sizing.
  - row_state_t enum {IDLE,WAIT_OPS,READY,EXEC}.
  - TAG_READY=0 constant.
- Sub-module rstat_table: REG_W-indexed TAG_W array with 3 combinational read ports, 1 set port and NUM_FU clear ports, with set-over-clear priority.

Test Plan:
- After reset, dispatch ALU rd=3 rs1=1 rs2=2 -> accept; issue_valid[ALU]=1 next cycle; RSTAT[3]=1.
- ALU writing r3 is busy; dispatch BRANCH rs1=3 -> t1=1, issue_valid[BRANCH]=0. ALU completes -> t1=0, issue_valid[BRANCH]=1 next cycle.
- ALU busy with rd=5; dispatch LD_ST rd=5 -> disp_hazard=1. Dispatch ALU any -> disp_hazard=1 (structural).
- BRANCH in READY reading r4, ALU EXEC with rd=4 -> wb_ok[ALU]=0. BRANCH issues -> wb_ok[ALU]=1.
- ALU completes rd=7 in the same cycle LD_ST dispatches rs1=7 -> LD_ST t1=0 and issue_valid next cycle. With SCOREBOARD_WB_RELEASE_EN, same-cycle ALU dispatch accepted.
- RST pulse with all three rows busy -> next cycle all IDLE, issue_valid=0, RSTAT clear, dispatch accepted.
